// File: rtl/att_residual_add_if.sv
// Token streams around the residual adder: residual/attention inputs and the
// drained output with its ready handshake.
interface att_residual_add_if #(
  parameter int DW = 16
);
  logic [DW-1:0] res_in;
  logic          res_valid;
  logic [DW-1:0] att_in;
  logic          att_flag;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output res_in, res_valid, att_in, att_flag, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  res_in, res_valid, att_in, att_flag, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/att_residual_add.sv
// Residual add after the attention core: buffer N residual tokens, add each
// attention token to its residual, then drain. ATT_RES_SAT_EN selects clamp+ovf.
module att_residual_add #(
  parameter int DW = 16,
  parameter int N  = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  att_residual_add_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  localparam int             CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT_ATT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wr;
  logic [CW-1:0] r_rd;
  logic [DW-1:0] r_res [N];
  logic [DW-1:0] r_out [N];
  logic [DW-1:0] w_sum;
  logic          w_start;
  logic          w_res_fire;
  logic          w_att_fire;
  logic          w_xfer;

  assign w_start    = (r_state == S_IDLE)     && start;
  assign w_res_fire = (r_state == S_CAPTURE)  && bus.res_valid;
  assign w_att_fire = (r_state == S_WAIT_ATT) && bus.att_flag;
  assign w_xfer     = (r_state == S_DRAIN)    && bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (start) w_next = S_CAPTURE;
      S_CAPTURE:  if (bus.res_valid && r_wr == LAST) w_next = S_WAIT_ATT;
      S_WAIT_ATT: if (bus.att_flag && r_wr == LAST) w_next = S_DRAIN;
      S_DRAIN:    if (bus.out_ready && r_rd == LAST) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // wr is reused: residual write index in CAPTURE, sum index in WAIT_ATT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_start) begin
        r_wr <= '0;
        r_rd <= '0;
      end else if (w_res_fire) begin
        r_wr <= (r_wr == LAST) ? '0 : r_wr + CW'(1);
      end else if (w_att_fire) begin
        if (r_wr != LAST) r_wr <= r_wr + CW'(1);
      end
      if (w_xfer && r_rd != LAST) r_rd <= r_rd + CW'(1);
    end
  end

`ifdef ATT_RES_SAT_EN
  logic [DW:0] w_sum_ext;
  logic        w_clamp;

  // Signs of the DW+1 result disagree exactly when the DW-bit result overflowed
  assign w_sum_ext = {bus.att_in[DW-1], bus.att_in} + {r_res[r_wr][DW-1], r_res[r_wr]};
  assign w_clamp   = w_sum_ext[DW] ^ w_sum_ext[DW-1];
  assign w_sum     = !w_clamp       ? w_sum_ext[DW-1:0] :
                     w_sum_ext[DW]  ? {1'b1, {(DW-1){1'b0}}} :
                                      {1'b0, {(DW-1){1'b1}}};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       ovf <= 1'b0;
    else if (w_start)                ovf <= 1'b0;
    else if (w_att_fire && w_clamp)  ovf <= 1'b1;
  end
`else
  assign w_sum = bus.att_in + r_res[r_wr];
  assign ovf   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_res[i] <= '0;
        r_out[i] <= '0;
      end
    end else begin
      if (w_res_fire) r_res[r_wr] <= bus.res_in;
      if (w_att_fire) r_out[r_wr] <= w_sum;
    end
  end

  always_comb begin
    bus.out_valid = (r_state == S_DRAIN);
    bus.out_data  = (r_state == S_DRAIN) ? r_out[r_rd] : '0;
    busy          = (r_state != S_IDLE);
    done          = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_att_residual_add.sv
// Bench for att_residual_add: directed frames against an arithmetic model of
// the residual sum, with literal expectations for the reference vectors.
module tb_att_residual_add;
  localparam int DW = 16;
  localparam int N  = 5;

  logic clk = 1'b0;
  logic rstn;
  logic start;
  logic busy, done, ovf;

  att_residual_add_if #(.DW(DW)) bus ();

  att_residual_add #(.DW(DW), .N(N)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] obs_q  [$];
  logic [DW-1:0] xfer_q [$];
  bit exp_ovf;

  logic [DW-1:0] ra [N] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
  logic [DW-1:0] aa [N] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
  logic [DW-1:0] ea [N] = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd55};
  logic [DW-1:0] rs [N] = '{16'h7FF0, 16'h8000, 16'd1, 16'd2, 16'd3};
  logic [DW-1:0] as [N] = '{16'h0020, 16'hFFFF, 16'd1, 16'd1, 16'd1};
`ifdef ATT_RES_SAT_EN
  logic [DW-1:0] es [N] = '{16'h7FFF, 16'h8000, 16'd2, 16'd3, 16'd4};
  bit es_ovf = 1'b1;
`else
  logic [DW-1:0] es [N] = '{16'h8010, 16'h7FFF, 16'd2, 16'd3, 16'd4};
  bit es_ovf = 1'b0;
`endif
  logic [DW-1:0] ebp [8] = '{16'd11, 16'd22, 16'd22, 16'd22, 16'd22, 16'd33, 16'd44, 16'd55};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {ovf, value}: sum of two signed tokens under the configured overflow rule
  function automatic logic [DW:0] model(input logic [DW-1:0] r, input logic [DW-1:0] a);
    int s;
    int maxv;
    int minv;
    s    = int'($signed(r)) + int'($signed(a));
    maxv = (1 << (DW - 1)) - 1;
    minv = -(1 << (DW - 1));
`ifdef ATT_RES_SAT_EN
    if (s > maxv) return {1'b1, DW'(maxv)};
    if (s < minv) return {1'b1, DW'(minv)};
`endif
    return {1'b0, DW'(s)};
  endfunction

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (done) done_cnt++;
      if (bus.out_valid) begin
        obs_q.push_back(bus.out_data);
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_xfer: got %0h expected none at %0t", bus.out_data, $time);
          end else begin
            chk("out_data", bus.out_data, exp_q.pop_front());
          end
          xfer_q.push_back(bus.out_data);
        end
      end else begin
        chk("idle_out_data", bus.out_data, 0);
      end
    end
  end

  // mode 0 plain, 1 backpressure, 2 stray inputs/start, 3 reset after 2 att samples
  task automatic run_frame(input logic [DW-1:0] r [N], input logic [DW-1:0] a [N], input int mode);
    logic [DW:0] m;
    bit found;
    time t0;
    obs_q.delete();
    xfer_q.delete();
    done_cnt = 0;
    exp_ovf  = 1'b0;
    if (mode != 3) begin
      for (int i = 0; i < N; i++) begin
        m = model(r[i], a[i]);
        exp_q.push_back(m[DW-1:0]);
        exp_ovf |= m[DW];
      end
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ovf_cleared", ovf, 0);
    if (mode == 2) begin
      bus.att_flag = 1'b1; bus.att_in = 16'h1234;
      @(posedge clk); #1 bus.att_flag = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      bus.res_valid = 1'b1; bus.res_in = r[i];
      @(posedge clk); #1;
    end
    bus.res_valid = 1'b0;
    if (mode == 2) begin
      bus.res_valid = 1'b1; bus.res_in = 16'h5555; start = 1'b1;
      @(posedge clk); #1 bus.res_valid = 1'b0; start = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (mode == 3 && i == 2) begin
        chk("busy_wait_att", busy, 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        exp_q.delete();
        #20 rstn = 1'b1;
        return;
      end
      bus.att_in = a[i]; bus.att_flag = 1'b1;
      if (i == N - 1) chk("no_valid_before_last_att", bus.out_valid, 0);
      @(posedge clk); #1;
    end
    bus.att_flag = 1'b0;
    @(negedge clk);
    chk("first_valid_latency", bus.out_valid, 1);
    t0 = $time;
    if (mode == 1) begin
      @(posedge clk); #1 bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.out_ready = 1'b1;
    end
    if (mode == 2) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    found = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) begin found = 1'b1; break; end
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end else begin
      chk("drain_cycles", 32'((($time - t0) / 10)), (mode == 1) ? N + 3 : N);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("done_pulses", done_cnt, 1);
    chk("tokens_left", exp_q.size(), 0);
    chk("xfer_count", xfer_q.size(), N);
    chk("ovf_sticky", ovf, exp_ovf);
  endtask

  task automatic chk_xfer(input string name, input logic [DW-1:0] e [N]);
    for (int i = 0; i < N; i++)
      chk(name, (i < xfer_q.size()) ? xfer_q[i] : 16'hDEAD, e[i]);
  endtask

  initial begin
    logic [DW:0] pin;
    rstn = 1'b0; start = 1'b0;
    bus.res_in = '0; bus.res_valid = 1'b0;
    bus.att_in = '0; bus.att_flag = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", ovf, 0);
    #10 rstn = 1'b1;

    pin = model(16'h7FF0, 16'h0020);
    chk("model_pos_edge", pin, {es_ovf, es[0]});
    pin = model(16'd2, 16'd20);
    chk("model_plain", pin, {1'b0, 16'd22});

    run_frame(ra, aa, 0);
    chk_xfer("basic_seq", ea);

    run_frame(rs, as, 0);
    chk_xfer("sat_seq", es);
    chk("sat_ovf", ovf, es_ovf);

    run_frame(ra, aa, 1);
    chk("bp_obs_len", obs_q.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("bp_obs", (i < obs_q.size()) ? obs_q[i] : 16'hDEAD, ebp[i]);
    chk_xfer("bp_seq", ea);

    run_frame(ra, aa, 3);
    chk("post_rst_busy", busy, 0);
    run_frame(ra, aa, 0);
    chk_xfer("post_rst_seq", ea);

    run_frame(ra, aa, 2);
    chk_xfer("restart_ignored_seq", ea);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
